keypad_scanner: RTL and testbench

Scan controller for the calculator's 4x4 matrix keypad. Drives one keypad row low at a time and samples the four column inputs. When a key closes, the block holds that row and debounces the key for DB_CYCLES clocks. It then emits one registered key code with a single-cycle strobe to the calculator front end, and waits for a debounced release before scanning again.

---
 rtl/keypad_scanner.sv | 140 ++++++++++++++
 tb/tb_keypad_scanner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Scan controller for a 4x4 active-low matrix keypad: walks the rows, debounces a
// closed key, emits one registered key code with a one-cycle strobe, then waits for release.
module keypad_scanner #(
    parameter int SCAN_CYCLES = 1000,
    parameter int DB_CYCLES   = 1000000
) (
    input  logic       clk,
    input  logic       rst_ext,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int MAX_CYCLES = (SCAN_CYCLES > DB_CYCLES) ? SCAN_CYCLES : DB_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        ACCEPT,
        RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    col_meta_q, col_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    r_q, r_d;
    logic [1:0]    c_q, c_d;
    logic [3:0]    row_out_q, row_out_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic          any_low;
    logic [1:0]    low_idx;

    // State register, synchronizer and all datapath flops
    always_ff @(posedge clk) begin
        if (rst_ext) begin
            state_q     <= SCAN;
            col_meta_q  <= 4'hF;
            col_s_q     <= 4'hF;
            cnt_q       <= '0;
            r_q         <= 2'd0;
            c_q         <= 2'd0;
            row_out_q   <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_meta_q  <= col_in;
            col_s_q     <= col_meta_q;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            c_q         <= c_d;
            row_out_q   <= row_out_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    always_comb begin
        any_low = (col_s_q != 4'hF);
        if (!col_s_q[0])      low_idx = 2'd0;
        else if (!col_s_q[1]) low_idx = 2'd1;
        else if (!col_s_q[2]) low_idx = 2'd2;
        else                  low_idx = 2'd3;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:     if (cnt_q == SCAN_LAST && any_low) state_d = DEBOUNCE;
            DEBOUNCE: begin
                if (col_s_q[c_q])          state_d = SCAN;
                else if (cnt_q == DB_LAST) state_d = ACCEPT;
            end
            ACCEPT:   state_d = RELEASE;
            RELEASE:  if (!any_low && cnt_q == DB_LAST) state_d = SCAN;
            default:  state_d = SCAN;
        endcase
    end

    // Outputs are loaded on the transition into ACCEPT so the strobe is visible during ACCEPT
    always_comb begin
        cnt_d       = cnt_q;
        r_d         = r_q;
        c_d         = c_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (any_low) c_d = low_idx;
                    else         r_d = r_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DEBOUNCE: begin
                if (col_s_q[c_q]) begin
                    cnt_d = '0;
                    r_d   = r_q + 2'd1;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d       = '0;
                    key_code_d  = {r_q, c_q};
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACCEPT: cnt_d = '0;
            RELEASE: begin
                if (any_low) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                    r_d        = 2'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: cnt_d = '0;
        endcase
        row_out_d = ~(4'b0001 << r_d);
    end

    assign row_out   = row_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the columns,
// expected key codes go into a scoreboard queue and a negedge monitor checks every strobe.
module tb_keypad_scanner;
    localparam int SCAN_CYCLES   = 4;
    localparam int DB_CYCLES     = 8;
    // Key already down when its row is driven: sampled at end of settle, then debounce, then accept
    localparam int PRESS_LATENCY = (SCAN_CYCLES - 1) + DB_CYCLES + 1;

    logic        clk = 1'b0;
    logic        rst_ext = 1'b1;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;

    int          total_checks = 0;
    int          passed_checks = 0;
    logic [3:0]  exp_q[$];

    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [3:0]  prev_row = 4'b1110;
    logic        prev_valid = 1'b0;
    logic        prev_held = 1'b0;
    logic        prev_rst = 1'b1;
    int          last_change = 0;
    int          high_run = 0;
    logic [3:0]  sync1 = 4'hF;
    logic [3:0]  sync2 = 4'hF;

    keypad_scanner #(
        .SCAN_CYCLES(SCAN_CYCLES),
        .DB_CYCLES  (DB_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_ext  (rst_ext),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a closed key pulls its column low only while its row is driven low
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && row_out[r] == 1'b0) col_in[c] = 1'b0;
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        sync1 <= col_in;
        sync2 <= sync1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) passed_checks++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    endtask

    // Monitor: pops the scoreboard on each strobe and checks press/release timing
    always @(negedge clk) begin
        if (mon_en) begin
            if (row_out != prev_row) last_change = cyc;
            if (key_valid === 1'b1) begin
                checkOutput("valid_single_cycle", prev_valid, 0);
                checkOutput("held_with_valid", key_held, 1);
                checkOutput("valid_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    checkOutput("key_code", key_code, exp_q.pop_front());
                    checkOutput("press_latency", cyc - last_change, PRESS_LATENCY);
                end
            end
            if (prev_held && !key_held && !prev_rst)
                checkOutput("release_latency", high_run, DB_CYCLES);
        end
        if (sync2 == 4'hF) high_run++;
        else               high_run = 0;
        prev_row   = row_out;
        prev_valid = key_valid;
        prev_held  = key_held;
        prev_rst   = rst_ext;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitRow(input int row, input logic level);
        int n = 0;
        while (row_out[row] !== level && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("row_wait", row_out[row], level);
    endtask

    task automatic waitHeld(input logic level, input int bound);
        int n = 0;
        while (key_held !== level && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("held_wait", key_held, level);
    endtask

    // Close a set of keys in one row while that row is not driven; the accepted code is the lowest column
    task automatic applyStimulus(input int row, input logic [3:0] cols);
        logic [1:0] lowest = 2'd0;
        logic [1:0] rr;
        for (int c = 3; c >= 0; c--) if (cols[c]) lowest = 2'(c);
        rr = 2'(row);
        waitRow(row, 1'b1);
        keys[row*4 +: 4] = cols;
        exp_q.push_back({rr, lowest});
    endtask

    initial begin
        logic [3:0] exp_row;

        rst_ext = 1'b1;
        tick(3);
        rst_ext = 1'b0;
        mon_en  = 1'b1;
        checkOutput("reset_row_out", row_out, 4'b1110);
        checkOutput("reset_key_code", key_code, 4'h0);
        checkOutput("reset_key_valid", key_valid, 0);
        checkOutput("reset_key_held", key_held, 0);

        for (int i = 1; i < 64; i++) begin
            tick(1);
            exp_row = ~(4'b0001 << ((i / SCAN_CYCLES) % 4));
            checkOutput("idle_row_out", row_out, exp_row);
        end
        checkOutput("idle_key_code", key_code, 4'h0);
        checkOutput("idle_key_held", key_held, 0);

        applyStimulus(2, 4'b0010);
        tick(40);
        keys = '0;
        waitHeld(1'b0, 40);

        // Bounce: key closes as row 1 is driven, opens for one clock mid-debounce, then closes again
        waitRow(1, 1'b1);
        waitRow(1, 1'b0);
        keys[7] = 1'b1;
        exp_q.push_back(4'h7);
        tick(5);
        keys[7] = 1'b0;
        tick(1);
        keys[7] = 1'b1;
        tick(30);
        keys = '0;
        waitHeld(1'b0, 40);

        // Reset three clocks into debounce, with the key opening as reset hits
        waitRow(3, 1'b1);
        keys[14] = 1'b1;
        waitRow(3, 1'b0);
        tick(6);
        rst_ext  = 1'b1;
        keys     = '0;
        tick(1);
        rst_ext  = 1'b0;
        checkOutput("midrst_row_out", row_out, 4'b1110);
        checkOutput("midrst_key_code", key_code, 4'h0);
        checkOutput("midrst_key_valid", key_valid, 0);
        checkOutput("midrst_key_held", key_held, 0);
        tick(40);

        applyStimulus(0, 4'b0101);
        waitHeld(1'b1, 40);
        tick(5);
        keys[0] = 1'b0;
        tick(20);
        checkOutput("double_still_held", key_held, 1);
        keys = '0;
        waitHeld(1'b0, 40);

        // Release glitch: open 6, close 1, then open for good
        applyStimulus(3, 4'b0001);
        waitHeld(1'b1, 40);
        tick(5);
        keys[12] = 1'b0;
        tick(6);
        keys[12] = 1'b1;
        tick(1);
        keys[12] = 1'b0;
        tick(7);
        checkOutput("glitch_still_held", key_held, 1);
        waitHeld(1'b0, 20);

        for (int n = 0; n < 12; n++) begin
            int         row;
            logic [3:0] cols;
            row  = int'($urandom_range(0, 3));
            cols = 4'($urandom_range(1, 15));
            applyStimulus(row, cols);
            tick(int'($urandom_range(30, 45)));
            keys = '0;
            waitHeld(1'b0, 60);
            tick(int'($urandom_range(0, 10)));
        end

        tick(20);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
